// File: rtl/regfile.sv
// 32 x 32-bit MIPS-style register file: two combinational read ports, one clocked write port, r0 fixed at zero.
// Optional write-to-read forwarding is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_en_s;

    assign wr_en_s = rst && we && (waddr != {ADDR_W{1'b0}});

    // Next-state: reset clears everything and drops the write; r0 is never written
    always_comb begin
        regs_d = regs_q;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_d[i] = {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = {DATA_W{1'b0}};
    end

    // Storage update on the rising edge
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read port 1: address 0 is forced to zero so it is defined even before the first reset
    always_comb begin
        rdata1 = {DATA_W{1'b0}};
        if (raddr1 == {ADDR_W{1'b0}}) begin
            rdata1 = {DATA_W{1'b0}};
`ifdef REGFILE_WR_BYPASS_EN
        end else if (wr_en_s && (raddr1 == waddr)) begin
            rdata1 = wdata;
`endif
        end else begin
            rdata1 = regs_q[raddr1];
        end
    end

    // Read port 2: same decoding as port 1
    always_comb begin
        rdata2 = {DATA_W{1'b0}};
        if (raddr2 == {ADDR_W{1'b0}}) begin
            rdata2 = {DATA_W{1'b0}};
`ifdef REGFILE_WR_BYPASS_EN
        end else if (wr_en_s && (raddr2 == waddr)) begin
            rdata2 = wdata;
`endif
        end else begin
            rdata2 = regs_q[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus a random phase against an array model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    int          n_checks;
    int          n_fails;
    logic [31:0] mdl [32];

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WR_BYPASS_EN
        if (rst && we && (waddr != 5'd0) && (a == waddr)) return wdata;
`endif
        return mdl[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_p1"}, rdata1, exp_read(raddr1));
        check({tag, "_p2"}, rdata2, exp_read(raddr2));
    endtask

    // One rising edge; the model absorbs the inputs held across the edge
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            mdl[waddr] = wdata;
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rst = 1'b0; we = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0; waddr = 5'd0; wdata = 32'h0;
        #2;
        check("r0_before_reset", rdata1, 32'h0);

        tick();
        rst = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
            check_ports("post_reset");
        end

        // Write sweep, r0 included (must be ignored)
        for (int a = 0; a < 32; a++) begin
            we = 1'b1; waddr = 5'(a); wdata = 32'h00FF00FF + 32'(a);
            tick();
        end
        we = 1'b0;
        for (int a = 31; a >= 0; a--) begin
            raddr1 = 5'(a); raddr2 = 5'(a); #1;
            check("sweep_p1", rdata1, (a == 0) ? 32'h0 : 32'h00FF00FF + 32'(a));
            check("sweep_p2", rdata2, (a == 0) ? 32'h0 : 32'h00FF00FF + 32'(a));
        end

        // Dual read, both ports stepping down together
        raddr1 = 5'd31; raddr2 = 5'd15; #1;
        check("dual_r31", rdata1, 32'h00FF011E);
        check("dual_r15", rdata2, 32'h00FF010E);
        for (int k = 0; k < 8; k++) begin
            tick();
            raddr1 = raddr1 - 5'd1; raddr2 = raddr2 - 5'd1; #1;
            check_ports("dual_step");
        end

        // Reset edge with a pending write: write is dropped
        rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        rst = 1'b1; we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(a); #1;
            check("reset_p1", rdata1, 32'h0);
            check("reset_p2", rdata2, 32'h0);
        end

        // Write enable off
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_0007;
        tick();
        we = 1'b0; wdata = 32'h12345678; raddr1 = 5'd7;
        for (int k = 0; k < 3; k++) tick();
        check("we_off_r7", rdata1, 32'hA5A5_0007);

        // r0 protection
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        tick();
        check("r0_protect", rdata1, 32'h0);
        we = 1'b0;

        // Same-cycle write/read hazard on r9
        we = 1'b1; waddr = 5'd9; wdata = 32'h1111_2222;
        tick();
        wdata = 32'hCAFEF00D; raddr1 = 5'd9; raddr2 = 5'd9; #1;
`ifdef REGFILE_WR_BYPASS_EN
        check("hazard_pre", rdata1, 32'hCAFEF00D);
`else
        check("hazard_pre", rdata1, 32'h1111_2222);
`endif
        check_ports("hazard_pre_model");
        tick();
        we = 1'b0; #1;
        check("hazard_post", rdata1, 32'hCAFEF00D);

        // Random traffic, checked before every edge
        for (int k = 0; k < 300; k++) begin
            rst    = ($urandom_range(0, 39) != 0);
            we     = $urandom_range(0, 2) != 0;
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            #1;
            check_ports("random");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
